// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo: single-clock synchronous FIFO backed by a register array.
//
// - Write accepted on wr_en && !full; read accepted on rd_en && !empty.
// - Read data is registered (one-cycle latency). dout holds between reads.
// - There is no pass-through path: a read and a write in the same cycle on an
//   empty FIFO accepts the write only.
// - DEPTH may be any value >= 2. Pointers wrap by explicit compare, so
//   non-power-of-two depths are supported.
// - full/empty/almost_* are decoded from the registered count only. This keeps
//   them free of any combinational path from wr_en, rd_en or din.
// - wr_err/rd_err are registered one-cycle pulses for rejected requests.
// -----------------------------------------------------------------------------
module fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           wr_err,
  output logic                           rd_err
);

  // Width of the occupancy counter (must represent 0..DEPTH inclusive).
  localparam int CW = $clog2(DEPTH + 1);
  // Width of the storage pointers (must represent 0..DEPTH-1).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COUNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THRESH  = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_THRESH  = CW'(ALMOST_EMPTY_THRESH);

  localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  // Advance a storage pointer, returning to slot 0 after the last slot.
  // An explicit compare is used so that any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  // Storage and state registers.
  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  wr_err_r;
  logic                  rd_err_r;

  // Decoded status and handshake signals.
  logic                  full_s;
  logic                  empty_s;
  logic                  almost_full_s;
  logic                  almost_empty_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;
  logic                  wr_reject_s;
  logic                  rd_reject_s;
  logic [CW-1:0]         count_next_s;

  // Status flags decode from the registered occupancy only.
  always_comb begin
    full_s         = (count_r == COUNT_MAX);
    empty_s        = (count_r == COUNT_ZERO);
    almost_full_s  = (count_r >= AF_THRESH);
    almost_empty_s = (count_r <= AE_THRESH);
  end

  // Qualify requests against the current full/empty state.
  always_comb begin
    wr_accept_s = wr_en & ~full_s;
    rd_accept_s = rd_en & ~empty_s;
    wr_reject_s = wr_en &  full_s;
    rd_reject_s = rd_en &  empty_s;
  end

  // Next occupancy: up on write-only, down on read-only, otherwise unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_next_s = count_r + COUNT_ONE;
      2'b01:   count_next_s = count_r - COUNT_ONE;
      2'b11:   count_next_s = count_r;
      default: count_next_s = count_r;
    endcase
  end

  // Storage array: written only on accepted writes, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Write pointer advances on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
    end else if (wr_accept_s) begin
      wr_ptr_r <= ptr_next(wr_ptr_r);
    end
  end

  // Read pointer and registered read data; dout holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= PTR_ZERO;
      dout_r   <= {DATA_WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_ptr_r <= ptr_next(rd_ptr_r);
      dout_r   <= mem_r[rd_ptr_r];
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= COUNT_ZERO;
    end else begin
      count_r <= count_next_s;
    end
  end

  // Error pulses: re-evaluated every edge, so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
      rd_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_reject_s;
      rd_err_r <= rd_reject_s;
    end
  end

  assign dout         = dout_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = almost_full_s;
  assign almost_empty = almost_empty_s;
  assign wr_err       = wr_err_r;
  assign rd_err       = rd_err_r;

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo: self-checking bench for fifo. A queue-based reference model tracks
// contents, expected dout and error pulses. Directed scenarios are followed by
// a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          wr_err;
  logic          rd_err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_dout;
  logic          exp_wr_err;
  logic          exp_rd_err;

  fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .ALMOST_FULL_THRESH(AFT), .ALMOST_EMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference model.
  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":dout"},  32'(dout),  32'(exp_dout));
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":full"},  32'(full),  32'(n == DEPTH));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":afull"}, 32'(almost_full),  32'(n >= AFT));
    chk({tag, ":aempty"},32'(almost_empty), 32'(n <= AET));
    chk({tag, ":wr_err"},32'(wr_err), 32'(exp_wr_err));
    chk({tag, ":rd_err"},32'(rd_err), 32'(exp_rd_err));
  endtask

  // One clock cycle: drive, update model from pre-edge state, check after edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    int  n;
    logic was_full, was_empty;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    n          = model_q.size();
    was_full   = (n == DEPTH);
    was_empty  = (n == 0);
    exp_wr_err = w && was_full;
    exp_rd_err = r && was_empty;
    if (r && !was_empty) exp_dout = model_q.pop_front();
    if (w && !was_full)  model_q.push_back(d);
    #1;
    check_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout   = '0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] basic [5];
    logic [DW-1:0] v;
    basic[0] = 8'h24; basic[1] = 8'h81; basic[2] = 8'h09;
    basic[3] = 8'h63; basic[4] = 8'h0D;

    // ---------------- Reset ----------------
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    #20;
    check_all("reset");
    chk("reset:empty_const", 32'(empty), 32'd1);
    chk("reset:dout_const",  32'(dout),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- Basic order ----------------
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, basic[i], "basic_wr");
    chk("basic:count5", 32'(count), 32'd5);
    chk("basic:notempty", 32'(empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, "basic_rd");
      chk("basic:order", 32'(dout), 32'(basic[i]));
    end
    chk("basic:final_empty", 32'(empty), 32'd1);

    // ---------------- Fill / overflow ----------------
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill_wr");
    chk("fill:full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'hFF, "overflow");
    chk("overflow:wr_err", 32'(wr_err), 32'd1);
    step(1'b0, 1'b0, 8'h00, "overflow_idle");
    chk("overflow:wr_err_drop", 32'(wr_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain");
      chk("drain:order", 32'(dout), 32'(i));
    end

    // ---------------- Underflow ----------------
    step(1'b0, 1'b1, 8'h00, "underflow");
    chk("underflow:rd_err", 32'(rd_err), 32'd1);
    chk("underflow:dout_hold", 32'(dout), 32'h0F);
    step(1'b0, 1'b0, 8'h00, "underflow_idle");

    // Simultaneous on empty: write only, rd_err pulses, dout unchanged.
    step(1'b1, 1'b1, 8'h77, "simul_empty");
    chk("simul_empty:count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 8'h00, "simul_empty_rd");
    chk("simul_empty:data", 32'(dout), 32'h77);

    // ---------------- Simultaneous / wrap ----------------
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "pre3");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, DW'(8'h43 + i), "simul3");
      chk("simul3:delay", 32'(dout), 32'(8'h40 + i));
    end
    chk("simul3:count", 32'(count), 32'd3);
    // Top up to full, then simultaneous on full.
    while (model_q.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom), "topup");
    step(1'b1, 1'b1, 8'hEE, "simul_full");
    chk("simul_full:count", 32'(count), 32'(DEPTH - 1));
    chk("simul_full:wr_err", 32'(wr_err), 32'd1);
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, "drain2");

    // ---------------- Randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           DW'($urandom), "random");
    end

    // ---------------- Reset mid-operation ----------------
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, "drain3");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(8'hB0 + i), "mid_wr");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5, "post_reset_wr");
    step(1'b0, 1'b1, 8'h00, "post_reset_rd");
    chk("post_reset:data", 32'(dout), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
